// File: rtl/arb2_4_pkg.sv
// Shared encodings for the two-requester arbiter in front of mux2_4.
package arb2_4_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/mux2_4.sv
// 2:1 multiplexer for the shared word datapath (sel=0 picks a, sel=1 picks b).
module mux2_4 #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/arb2_4.sv
// Round-robin arbiter for two requesters sharing mux2_4, with a one-entry
// output buffer, valid/ready downstream handshake and per-source counters.
import arb2_4_pkg::*;

module arb2_4 #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  state_e             state_q;
  logic               prio_q;
  logic               sel_q;
  logic [WIDTH-1:0]   out_data_q;
  logic               out_src_q;
  logic [CNT_W-1:0]   cnt_a_q;
  logic [CNT_W-1:0]   cnt_b_q;

  logic               any_req;
  logic               can_load;
  logic               winner;
  logic               grant;
  logic [WIDTH-1:0]   mux_y;

  // Arbitration: a lone requester wins; on contention the priority pointer decides.
  always_comb begin
    any_req  = 1'b0;
    can_load = 1'b0;
    winner   = SRC_A;
    grant    = 1'b0;
    gnt_a    = 1'b0;
    gnt_b    = 1'b0;
    sel      = sel_q;

    any_req  = req_a | req_b;
    can_load = (state_q == EMPTY) | out_ready;
    winner   = req_b & (~req_a | prio_q);
    // rst_n gating keeps grants low while the block is held in reset.
    grant    = rst_n & can_load & any_req;
    gnt_a    = grant & (winner == SRC_A);
    gnt_b    = grant & (winner == SRC_B);
    if (grant) begin
      sel = winner;
    end
  end

  mux2_4 #(.WIDTH(WIDTH)) u_mux (
    .a   (data_a),
    .b   (data_b),
    .sel (sel),
    .y   (mux_y)
  );

  // Buffer FSM, priority pointer and counters; everything holds unless a load slot is open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      prio_q     <= SRC_A;
      sel_q      <= SRC_A;
      out_data_q <= '0;
      out_src_q  <= SRC_A;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
    end else if (can_load) begin
      state_q <= any_req ? FULL : EMPTY;
      if (any_req) begin
        out_data_q <= mux_y;
        out_src_q  <= sel;
        prio_q     <= ~sel;
        sel_q      <= sel;
        if (sel == SRC_A) begin
          cnt_a_q <= CNT_W'(cnt_a_q + CNT_W'(1));
        end else begin
          cnt_b_q <= CNT_W'(cnt_b_q + CNT_W'(1));
        end
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign cnt_a     = cnt_a_q;
  assign cnt_b     = cnt_b_q;

endmodule
